// File: rtl/bitwise_bist.sv
// Exhaustive self-test driver for an N-bit bitwise gate: walks all A/B pairs, checks the result.
// Two cycles per vector (drive, then sample); start is ignored while busy, no backpressure.
module bitwise_bist #(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [1:0]     op,
  output logic [N-1:0]   a_out,
  output logic [N-1:0]   b_out,
  input  logic [N-1:0]   s_in,
  output logic           busy,
  output logic           done,
  output logic           pass,
  output logic [2*N:0]   err_count,
  output logic [N-1:0]   fail_a,
  output logic [N-1:0]   fail_b,
  output logic [N-1:0]   fail_s
);

  localparam int VW = 2 * N;
  localparam logic [VW-1:0] VEC_ONE = {{(VW-1){1'b0}}, 1'b1};
  localparam logic [VW:0]   ERR_ONE = {{VW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [VW-1:0] vec_q, vec_d;
  logic [1:0]    op_q, op_d;
  logic [VW:0]   err_q, err_d;
  logic [N-1:0]  fail_a_q, fail_a_d;
  logic [N-1:0]  fail_b_q, fail_b_d;
  logic [N-1:0]  fail_s_q, fail_s_d;
  logic          ff_q, ff_d;

  logic [N-1:0]  a_cur, b_cur, expected;
  logic          mismatch;

  assign a_cur = vec_q[VW-1:N];
  assign b_cur = vec_q[N-1:0];

  always_comb begin
    expected = '0;
    case (op_q)
      2'b00:   expected = a_cur & b_cur;
      2'b01:   expected = a_cur | b_cur;
      2'b10:   expected = a_cur ^ b_cur;
      default: expected = ~(a_cur & b_cur);
    endcase
    // Mismatch unless equality is positively established, so X/Z on s_in counts as a failure.
    mismatch = 1'b1;
    if (s_in == expected) mismatch = 1'b0;
  end

  always_comb begin
    state_d  = state_q;
    vec_d    = vec_q;
    op_d     = op_q;
    err_d    = err_q;
    fail_a_d = fail_a_q;
    fail_b_d = fail_b_q;
    fail_s_d = fail_s_q;
    ff_d     = ff_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          op_d     = op;
          vec_d    = '0;
          err_d    = '0;
          fail_a_d = '0;
          fail_b_d = '0;
          fail_s_d = '0;
          ff_d     = 1'b0;
          state_d  = S_SETTLE;
        end
      end
      S_SETTLE: state_d = S_SAMPLE;
      S_SAMPLE: begin
        if (mismatch) begin
          err_d = err_q + ERR_ONE;
          if (!ff_q) begin
            fail_a_d = a_cur;
            fail_b_d = b_cur;
            fail_s_d = s_in;
            ff_d     = 1'b1;
          end
        end
        if (vec_q == {VW{1'b1}}) begin
          state_d = S_DONE;
        end else begin
          vec_d   = vec_q + VEC_ONE;
          state_d = S_SETTLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      vec_q    <= '0;
      op_q     <= '0;
      err_q    <= '0;
      fail_a_q <= '0;
      fail_b_q <= '0;
      fail_s_q <= '0;
      ff_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      vec_q    <= vec_d;
      op_q     <= op_d;
      err_q    <= err_d;
      fail_a_q <= fail_a_d;
      fail_b_q <= fail_b_d;
      fail_s_q <= fail_s_d;
      ff_q     <= ff_d;
    end
  end

  assign a_out     = a_cur;
  assign b_out     = b_cur;
  assign busy      = (state_q == S_SETTLE) || (state_q == S_SAMPLE);
  assign done      = (state_q == S_DONE);
  assign pass      = done && (err_q == '0);
  assign err_count = err_q;
  assign fail_a    = fail_a_q;
  assign fail_b    = fail_b_q;
  assign fail_s    = fail_s_q;

endmodule
